// File: rtl/stream_demux_pkg.sv
// Shared constants for the stream_demux 1-to-2 steering demultiplexer.
package stream_demux_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned CNT_W     = 16;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO used as the per-output buffer of stream_demux.
// Storage is cleared on reset so the head word reads as 0 afterwards.
module demux_fifo
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Qualify requests so an overflow or underflow can never corrupt state.
  always_comb begin
    do_wr = wr_en && !full;
    do_rd = rd_en && !empty;
  end

  // Status flags derived from the registered count.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    rd_data = mem[rd_ptr];
  end

  // Storage array; cleared on reset so stale words are never presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux.sv
// 1-to-2 steering demultiplexer: each input word goes to out0 or out1 per in_sel,
// each output buffered by its own demux_fifo.
// Optional pop counters cnt0/cnt1 are enabled by defining STREAM_DEMUX_CNT_EN.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count0;
  logic [CW-1:0] count1;
  logic          empty0;
  logic          empty1;
  logic          full0;
  logic          full1;
  logic          wr0;
  logic          wr1;
  logic          rd0;
  logic          rd1;

  // Acceptance depends only on in_sel and registered occupancy; no path from outN_ready.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (in_sel == SEL_OUT1) begin
        in_ready = (count1 < CW'(DEPTH));
      end else begin
        in_ready = (count0 < CW'(DEPTH));
      end
    end
  end

  // Steer the accepted word to the selected FIFO; pop on the output handshake.
  always_comb begin
    wr0        = in_valid && in_ready && (in_sel == SEL_OUT0) && !full0;
    wr1        = in_valid && in_ready && (in_sel == SEL_OUT1) && !full1;
    out0_valid = !empty0;
    out1_valid = !empty1;
    rd0        = out0_valid && out0_ready;
    rd1        = out1_valid && out1_ready;
  end

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr0),
    .wr_data (in_data),
    .rd_en   (rd0),
    .rd_data (out0_data),
    .empty   (empty0),
    .full    (full0),
    .count   (count0)
  );

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr1),
    .wr_data (in_data),
    .rd_en   (rd1),
    .rd_data (out1_data),
    .empty   (empty1),
    .full    (full1),
    .count   (count1)
  );

`ifdef STREAM_DEMUX_CNT_EN
  // Per-output pop counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (rd0) begin
        cnt0 <= cnt0 + CNT_W'(1);
      end
      if (rd1) begin
        cnt1 <= cnt1 + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux (default DEPTH=2).
// Counter-wrap section runs only when STREAM_DEMUX_CNT_EN is defined.
module tb_stream_demux;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
`ifdef STREAM_DEMUX_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  stream_demux dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    in_data    = '0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;

    // Reset for two cycles.
    tick();
    tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out0_valid", 32'(out0_valid), 32'd0);
    check_eq("rst_out1_valid", 32'(out1_valid), 32'd0);
    check_eq("rst_out0_data", 32'(out0_data), 32'h0);
    check_eq("rst_out1_data", 32'(out1_data), 32'h0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // First push to out0, 1-cycle latency.
    in_data = 16'h1234; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("push0_valid", 32'(out0_valid), 32'd1);
    check_eq("push0_data", 32'(out0_data), 32'h1234);
    check_eq("push0_out1_idle", 32'(out1_valid), 32'd0);
    out0_ready = 1'b1;
    tick();
    out0_ready = 1'b0;
    check_eq("pop0_empty", 32'(out0_valid), 32'd0);

    // Fill FIFO1 and block on the third word.
    in_sel = 1'b1; in_valid = 1'b1; in_data = 16'hA001;
    tick();
    in_data = 16'hA002;
    check_eq("fill1_ready_2nd", 32'(in_ready), 32'd1);
    tick();
    in_data = 16'hA003;
    check_eq("fill1_block", 32'(in_ready), 32'd0);
    check_eq("fill1_head", 32'(out1_data), 32'hA001);
    tick();
    check_eq("hold1_valid", 32'(out1_valid), 32'd1);
    check_eq("hold1_data", 32'(out1_data), 32'hA001);
    out1_ready = 1'b1;
    #1;
    check_eq("no_ready_path", 32'(in_ready), 32'd0);
    tick();
    check_eq("drain1_head2", 32'(out1_data), 32'hA002);
    check_eq("drain1_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; out1_ready = 1'b0;
    check_eq("late_accept_head", 32'(out1_data), 32'hA003);
    check_eq("late_accept_valid", 32'(out1_valid), 32'd1);
    in_data = 16'hA004; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check_eq("fifo1_full", 32'(in_ready), 32'd0);

    // Independence: out0 accepts while out1 is full and stalled.
    in_sel = 1'b0; in_data = 16'h5555; in_valid = 1'b1;
    #1;
    check_eq("indep_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("indep_data", 32'(out0_data), 32'h5555);
    check_eq("indep_valid", 32'(out0_valid), 32'd1);
    check_eq("indep_out1_hold", 32'(out1_data), 32'hA003);

    // Simultaneous push and pop on FIFO0.
    out0_ready = 1'b1; in_data = 16'h0F0F; in_valid = 1'b1;
    tick();
    out0_ready = 1'b0; in_valid = 1'b0;
    check_eq("pushpop_head", 32'(out0_data), 32'h0F0F);
    check_eq("pushpop_valid", 32'(out0_valid), 32'd1);
    check_eq("pushpop_count1", 32'(in_ready), 32'd1);
    in_data = 16'h0BAD; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("fifo0_full", 32'(in_ready), 32'd0);

    // Reset mid-stream discards both FIFOs.
    rst = 1'b1;
    tick();
    check_eq("midrst_out0_valid", 32'(out0_valid), 32'd0);
    check_eq("midrst_out1_valid", 32'(out1_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("midrst_out0_data", 32'(out0_data), 32'h0);
    check_eq("midrst_ready_back", 32'(in_ready), 32'd1);
    in_data = 16'h7777; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("fresh_head", 32'(out0_data), 32'h7777);
    out0_ready = 1'b1;
    tick();
    out0_ready = 1'b0;
    check_eq("no_stale_words", 32'(out0_valid), 32'd0);

`ifdef STREAM_DEMUX_CNT_EN
    // Counter wrap: 65537 pops through out1.
    begin
      int pops;
      int cyc;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("cnt_rst0", 32'(cnt0), 32'h0);
      check_eq("cnt_rst1", 32'(cnt1), 32'h0);
      pops = 0;
      cyc  = 0;
      in_sel = 1'b1; in_valid = 1'b1; out1_ready = 1'b1;
      while (pops < 65537 && cyc < 70000) begin
        in_data = 16'(cyc);
        if (out1_valid) pops++;
        tick();
        cyc++;
      end
      in_valid = 1'b0; out1_ready = 1'b0;
      check_eq("cnt_wrap_pops", 32'(pops), 32'd65537);
      check_eq("cnt_wrap_cnt1", 32'(cnt1), 32'h0001);
      check_eq("cnt_wrap_cnt0", 32'(cnt0), 32'h0000);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
